// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data BRAM between the core LSU and the loader.
// Also decodes the board LED register and routes one-cycle read responses.
module dmem_arbiter #(
  parameter int unsigned    AW       = 12,
  parameter logic [AW-1:0]  LED_ADDR = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_be,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_be,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [15:0]   leds
);

  logic          last_q;
  logic          vld_q;
  logic          port_q;
  logic          isled_q;
  logic [15:0]   snap_q;
  logic [15:0]   leds_q;
  logic [15:0]   leds_d;
  logic [31:0]   r0_q;
  logic [31:0]   r1_q;

  logic          any_gnt;
  logic          sel;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_be;
  logic          s_led;
  logic [31:0]   resp;

  // Contention goes to the port that did not win last time.
  assign m0_gnt  = m0_req & (~m1_req | last_q);
  assign m1_gnt  = m1_req & (~m0_req | ~last_q);
  assign any_gnt = m0_gnt | m1_gnt;
  assign sel     = m1_gnt;

  assign s_we    = sel ? m1_we    : m0_we;
  assign s_addr  = sel ? m1_addr  : m0_addr;
  assign s_wdata = sel ? m1_wdata : m0_wdata;
  assign s_be    = sel ? m1_be    : m0_be;
  assign s_led   = (s_addr == LED_ADDR);

  assign mem_en    = any_gnt & ~s_led;
  assign mem_we    = (mem_en & s_we) ? s_be : 4'b0000;
  assign mem_addr  = s_addr;
  assign mem_wdata = s_wdata;

  always_comb begin
    leds_d = leds_q;
    if (any_gnt && s_led && s_we) begin
      if (s_be[0]) leds_d[7:0]  = s_wdata[7:0];
      if (s_be[1]) leds_d[15:8] = s_wdata[15:8];
    end
  end

  assign leds = leds_q;

  assign resp      = isled_q ? {16'h0, snap_q} : mem_rdata;
  assign m0_rvalid = vld_q & ~port_q;
  assign m1_rvalid = vld_q & port_q;
  assign m0_rdata  = m0_rvalid ? resp : r0_q;
  assign m1_rdata  = m1_rvalid ? resp : r1_q;

  // snap_q takes the pre-write LED value seen at the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      vld_q   <= 1'b0;
      port_q  <= 1'b0;
      isled_q <= 1'b0;
      snap_q  <= 16'h0;
      leds_q  <= 16'h0;
      r0_q    <= 32'h0;
      r1_q    <= 32'h0;
    end else begin
      if (any_gnt) last_q <= sel;
      vld_q   <= any_gnt & ~s_we;
      port_q  <= sel;
      isled_q <= s_led;
      snap_q  <= leds_q;
      leds_q  <= leds_d;
      if (m0_rvalid) r0_q <= resp;
      if (m1_rvalid) r1_q <= resp;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency BRAM model.
// Inputs change 1 ns after each rising edge; outputs are sampled before the next.
module tb_dmem_arbiter;

  localparam int unsigned   AW  = 12;
  localparam logic [AW-1:0] LED = 12'hFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata, m0_rdata;
  logic [3:0]    m0_be;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [3:0]    m1_be;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   leds;

  logic [31:0]   mem [0:(1<<AW)-1];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .LED_ADDR(LED)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .leds(leds)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | i;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h020;
    m0_wdata = 32'h0; m0_be = 4'b0000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h021;
    m1_wdata = 32'h0; m1_be = 4'b0000;

    #2;
    chk("rst_leds", {16'h0, leds}, 32'h0);
    chk("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    #18 rst_n = 1'b1;
    #2;
    chk("alt0_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("alt0_m1_gnt", {31'h0, m1_gnt}, 32'h0);
    cyc();
    chk("alt1_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    chk("alt1_m0_gnt", {31'h0, m0_gnt}, 32'h0);
    chk("alt1_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("alt1_m0_rdata", m0_rdata, 32'hA000_0020);
    cyc();
    chk("alt2_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("alt2_m1_gnt", {31'h0, m1_gnt}, 32'h0);
    chk("alt2_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("alt2_m1_rdata", m1_rdata, 32'hA000_0021);
    chk("alt2_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("alt2_m0_hold", m0_rdata, 32'hA000_0020);

    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    chk("idle_mem_en", {31'h0, mem_en}, 32'h0);
    chk("idle_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
    cyc();

    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h010;
    m0_wdata = 32'hDEAD_BEEF; m0_be = 4'b1111;
    #1;
    chk("wr_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("wr_mem_en", {31'h0, mem_en}, 32'h1);
    chk("wr_mem_we", {28'h0, mem_we}, 32'hF);
    chk("wr_mem_addr", {20'h0, mem_addr}, 32'h010);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    chk("wr_no_rvalid", {31'h0, m0_rvalid}, 32'h0);
    m0_we = 1'b0;
    #1;
    chk("rd_mem_we", {28'h0, mem_we}, 32'h0);
    cyc();
    chk("rd_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    m0_req = 1'b0;

    m1_req = 1'b1; m1_we = 1'b1; m1_addr = LED;
    m1_wdata = 32'h0000_A5C3; m1_be = 4'b0001;
    #1;
    chk("led1_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    chk("led1_mem_en", {31'h0, mem_en}, 32'h0);
    chk("led1_mem_we", {28'h0, mem_we}, 32'h0);
    cyc();
    chk("led1_leds", {16'h0, leds}, 32'h0000_00C3);
    m1_be = 4'b0010;
    #1;
    chk("led2_mem_en", {31'h0, mem_en}, 32'h0);
    cyc();
    chk("led2_leds", {16'h0, leds}, 32'h0000_A5C3);
    chk("led2_no_rvalid", {31'h0, m1_rvalid}, 32'h0);

    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = LED;
    m0_wdata = 32'hFFFF_1234; m0_be = 4'b1111;
    cyc();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = LED;
    #1;
    chk("ledrd_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    cyc();
    chk("ledrd_leds", {16'h0, leds}, 32'h0000_1234);
    chk("ledrd_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("ledrd_m1_rdata", m1_rdata, 32'h0000_1234);
    m1_req = 1'b0;

    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h010;
    m0_wdata = 32'h1111_2222; m0_be = 4'b0000;
    #1;
    chk("be0_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("be0_mem_we", {28'h0, mem_we}, 32'h0);
    cyc();
    chk("be0_no_rvalid", {31'h0, m0_rvalid}, 32'h0);
    m0_we = 1'b0;
    cyc();
    chk("be0_rdback", m0_rdata, 32'hDEAD_BEEF);

    m0_addr = 12'h011;
    cyc();
    m0_req = 1'b0;
    chk("rr_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rr_m0_rvalid_rst", {31'h0, m0_rvalid}, 32'h0);
    chk("rr_leds_rst", {16'h0, leds}, 32'h0);
    chk("rr_m0_rdata_rst", m0_rdata, 32'h0);
    m0_req = 1'b1; m1_req = 1'b1;
    m0_addr = 12'h012; m1_addr = 12'h013;
    #1 rst_n = 1'b1;
    #1;
    chk("rr_m0_prio", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    cyc();
    chk("rr_m1_next", {30'h0, m1_gnt, m0_gnt}, 32'h2);

    m0_req = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      m1_addr = 12'h030 + 12'(i);
      #1;
      chk($sformatf("b2b_gnt%0d", i), {31'h0, m1_gnt}, 32'h1);
      cyc();
      chk($sformatf("b2b_rv%0d", i), {31'h0, m1_rvalid}, 32'h1);
      chk($sformatf("b2b_rd%0d", i), m1_rdata, 32'hA000_0030 + i);
    end
    m1_req = 1'b0;
    cyc();
    chk("b2b_end_rvalid", {31'h0, m1_rvalid}, 32'h0);
    chk("b2b_hold", m1_rdata, 32'hA000_0033);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
